// File: rtl/motor_serpiente.sv
// -----------------------------------------------------------------------------
// motor_serpiente
// Snake body engine. It consumes the 3-bit accion code from the direction FSM.
// On every accepted step tick it moves the head one cell on a GRID_W x GRID_H
// grid and shifts the body behind it. It grows after food and scans the body
// for a self-collision. A registered random-read port serves the VGA renderer.
//
// Configuration macro:
//   SNAKE_WALL_KILL_EN  defined   -> leaving the grid is a collision (no shift,
//                                    head unchanged, straight to DEAD)
//                       undefined -> the head wraps around on each axis
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   paso        one-cycle step tick
//   accion      0 none, 1 up, 2 down, 3 left, 4 right (5..7 = none)
//   comer       one-cycle food-eaten pulse; the snake grows on the next move
//   seg_idx     segment index for the read port
//   seg_x/seg_y coordinates of seg[seg_idx], one cycle after seg_idx (0 if invalid)
//   seg_valido  seg_idx < longitud, registered
//   cabeza_x/y  head coordinates (seg[0])
//   longitud    current snake length
//   ocupado     high while a move is being applied or checked
//   choque      collision flag, sticky until rst
// -----------------------------------------------------------------------------
module motor_serpiente #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int X_W      = 5,
    parameter int Y_W      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         paso,
    input  logic [2:0]                   accion,
    input  logic                         comer,
    input  logic [$clog2(MAX_LEN)-1:0]   seg_idx,
    output logic [X_W-1:0]               seg_x,
    output logic [Y_W-1:0]               seg_y,
    output logic                         seg_valido,
    output logic [X_W-1:0]               cabeza_x,
    output logic [Y_W-1:0]               cabeza_y,
    output logic [$clog2(MAX_LEN+1)-1:0] longitud,
    output logic                         ocupado,
    output logic                         choque
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int L_W   = $clog2(MAX_LEN + 1);

`ifdef SNAKE_WALL_KILL_EN
    localparam bit WALL_KILL = 1'b1;
`else
    localparam bit WALL_KILL = 1'b0;
`endif

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [2:0]         dir_reg;
    logic [L_W-1:0]     longitud_reg;
    logic               pendiente_reg;
    logic               choque_reg;
    logic               ocupado_reg;
    logic [IDX_W-1:0]   chk_idx_reg;
    logic [X_W-1:0]     rd_x_reg;
    logic [Y_W-1:0]     rd_y_reg;
    logic               rd_valido_reg;

    // Flattened view of the segment registers, seg_*_arr[0] is the head.
    logic [X_W-1:0]     seg_x_arr [MAX_LEN];
    logic [Y_W-1:0]     seg_y_arr [MAX_LEN];

    logic [X_W-1:0]     head_x_next;
    logic [Y_W-1:0]     head_y_next;
    logic               wall_hit;
    logic               shift_en;
    logic               body_match;

    // -------------------------------------------------------------------------
    // Next head position. wall_hit flags that the move crosses a grid edge;
    // the wrapped coordinate is still produced so the default build can use it.
    // -------------------------------------------------------------------------
    always_comb begin
        head_x_next = seg_x_arr[0];
        head_y_next = seg_y_arr[0];
        wall_hit    = 1'b0;
        case (dir_reg)
            DIR_UP: begin
                if (seg_y_arr[0] == '0) begin
                    head_y_next = Y_MAX;
                    wall_hit    = 1'b1;
                end else begin
                    head_y_next = seg_y_arr[0] - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y_arr[0] == Y_MAX) begin
                    head_y_next = '0;
                    wall_hit    = 1'b1;
                end else begin
                    head_y_next = seg_y_arr[0] + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (seg_x_arr[0] == '0) begin
                    head_x_next = X_MAX;
                    wall_hit    = 1'b1;
                end else begin
                    head_x_next = seg_x_arr[0] - X_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (seg_x_arr[0] == X_MAX) begin
                    head_x_next = '0;
                    wall_hit    = 1'b1;
                end else begin
                    head_x_next = seg_x_arr[0] + X_W'(1);
                end
            end
            default: begin
                head_x_next = seg_x_arr[0];
                head_y_next = seg_y_arr[0];
            end
        endcase
    end

    // The body shifts only in MOVE, and never on a fatal wall crossing.
    assign shift_en = (state_reg == ST_MOVE) && !(WALL_KILL && wall_hit);

    // -------------------------------------------------------------------------
    // Segment shift register. Every segment shifts unconditionally on a move,
    // including the ones beyond longitud: the slot just past the tail holds the
    // old tail, which becomes visible when the length grows.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            localparam logic [X_W-1:0] RST_X = (gi < INIT_LEN) ? X_W'(GRID_W / 2 - gi) : '0;
            localparam logic [Y_W-1:0] RST_Y = (gi < INIT_LEN) ? Y_W'(GRID_H / 2) : '0;

            logic [X_W-1:0] x_reg;
            logic [Y_W-1:0] y_reg;
            logic [X_W-1:0] x_in;
            logic [Y_W-1:0] y_in;

            if (gi == 0) begin : g_head
                assign x_in = head_x_next;
                assign y_in = head_y_next;
            end else begin : g_body
                assign x_in = seg_x_arr[gi-1];
                assign y_in = seg_y_arr[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    x_reg <= RST_X;
                    y_reg <= RST_Y;
                end else if (shift_en) begin
                    x_reg <= x_in;
                    y_reg <= y_in;
                end
            end

            assign seg_x_arr[gi] = x_reg;
            assign seg_y_arr[gi] = y_reg;
        end
    endgenerate

    assign body_match = (seg_x_arr[chk_idx_reg] == seg_x_arr[0]) &&
                        (seg_y_arr[chk_idx_reg] == seg_y_arr[0]);

    // -------------------------------------------------------------------------
    // Control FSM, length, growth request and read port.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= 3'd0;
            longitud_reg  <= L_W'(INIT_LEN);
            pendiente_reg <= 1'b0;
            choque_reg    <= 1'b0;
            ocupado_reg   <= 1'b0;
            chk_idx_reg   <= '0;
            rd_x_reg      <= '0;
            rd_y_reg      <= '0;
            rd_valido_reg <= 1'b0;
        end else begin
            // Read port runs every cycle, independent of the FSM.
            if (L_W'(seg_idx) < longitud_reg) begin
                rd_x_reg      <= seg_x_arr[seg_idx];
                rd_y_reg      <= seg_y_arr[seg_idx];
                rd_valido_reg <= 1'b1;
            end else begin
                rd_x_reg      <= '0;
                rd_y_reg      <= '0;
                rd_valido_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (paso && (accion >= DIR_UP) && (accion <= DIR_RIGHT)) begin
                        dir_reg     <= accion;
                        state_reg   <= ST_MOVE;
                        ocupado_reg <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (WALL_KILL && wall_hit) begin
                        state_reg   <= ST_DEAD;
                        choque_reg  <= 1'b1;
                        ocupado_reg <= 1'b0;
                    end else begin
                        if (pendiente_reg && (longitud_reg < L_W'(MAX_LEN))) begin
                            longitud_reg <= longitud_reg + L_W'(1);
                        end
                        pendiente_reg <= 1'b0;
                        chk_idx_reg   <= IDX_W'(1);
                        state_reg     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (body_match) begin
                        state_reg   <= ST_DEAD;
                        choque_reg  <= 1'b1;
                        ocupado_reg <= 1'b0;
                    end else if (L_W'(chk_idx_reg) == longitud_reg - L_W'(1)) begin
                        state_reg   <= ST_IDLE;
                        ocupado_reg <= 1'b0;
                    end else begin
                        chk_idx_reg <= chk_idx_reg + IDX_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_DEAD;
                end
            endcase

            // Placed after the MOVE clear so food arriving during a move is
            // kept for the following one rather than lost.
            if (comer && (state_reg != ST_DEAD)) begin
                pendiente_reg <= 1'b1;
            end
        end
    end

    assign seg_x      = rd_x_reg;
    assign seg_y      = rd_y_reg;
    assign seg_valido = rd_valido_reg;
    assign cabeza_x   = seg_x_arr[0];
    assign cabeza_y   = seg_y_arr[0];
    assign longitud   = longitud_reg;
    assign ocupado    = ocupado_reg;
    assign choque     = choque_reg;

endmodule

// File: tb/tb_motor_serpiente.sv
// -----------------------------------------------------------------------------
// tb_motor_serpiente
// Directed bench for motor_serpiente with default parameters. Expected values
// are hand-computed constants for each scenario.
// -----------------------------------------------------------------------------
module tb_motor_serpiente;

    logic       clk;
    logic       rst;
    logic       paso;
    logic [2:0] accion;
    logic       comer;
    logic [3:0] seg_idx;
    logic [4:0] seg_x;
    logic [4:0] seg_y;
    logic       seg_valido;
    logic [4:0] cabeza_x;
    logic [4:0] cabeza_y;
    logic [4:0] longitud;
    logic       ocupado;
    logic       choque;

    int checks_cnt;
    int errors_cnt;

    motor_serpiente dut (
        .clk        (clk),
        .rst        (rst),
        .paso       (paso),
        .accion     (accion),
        .comer      (comer),
        .seg_idx    (seg_idx),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .seg_valido (seg_valido),
        .cabeza_x   (cabeza_x),
        .cabeza_y   (cabeza_y),
        .longitud   (longitud),
        .ocupado    (ocupado),
        .choque     (choque)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("check %s: %0d ok", tag, obs);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        paso    = 1'b0;
        accion  = 3'd0;
        comer   = 1'b0;
        seg_idx = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One step: paso for a single cycle, then wait (bounded) for ocupado to drop.
    task automatic step(input logic [2:0] a, input logic c);
        int n;
        @(negedge clk);
        paso   = 1'b1;
        accion = a;
        comer  = c;
        @(posedge clk);
        #1;
        paso   = 1'b0;
        accion = 3'd0;
        comer  = 1'b0;
        n = 0;
        while (ocupado && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 64) check("step_timeout_ocupado", {31'd0, ocupado}, 32'd0);
    endtask

    task automatic read_seg(input logic [3:0] idx, output logic [4:0] x,
                            output logic [4:0] y, output logic v);
        @(negedge clk);
        seg_idx = idx;
        @(posedge clk);
        #1;
        x = seg_x;
        y = seg_y;
        v = seg_valido;
    endtask

    initial begin
        logic [4:0] rx;
        logic [4:0] ry;
        logic       rv;
        int         n;
        checks_cnt = 0;
        errors_cnt = 0;
        rst     = 1'b1;
        paso    = 1'b0;
        accion  = 3'd0;
        comer   = 1'b0;
        seg_idx = 4'd0;

        // T1: reset state
        @(posedge clk);
        #1;
        check("rst_seg_valido", {31'd0, seg_valido}, 32'd0);
        check("rst_seg_x", {27'd0, seg_x}, 32'd0);
        do_reset();
        #1;
        check("t1_head_x", {27'd0, cabeza_x}, 32'd16);
        check("t1_head_y", {27'd0, cabeza_y}, 32'd12);
        check("t1_len", {27'd0, longitud}, 32'd3);
        check("t1_choque", {31'd0, choque}, 32'd0);
        check("t1_ocupado", {31'd0, ocupado}, 32'd0);
        read_seg(4'd1, rx, ry, rv);
        check("t1_seg1_x", {27'd0, rx}, 32'd15);
        check("t1_seg1_y", {27'd0, ry}, 32'd12);
        check("t1_seg1_v", {31'd0, rv}, 32'd1);
        read_seg(4'd2, rx, ry, rv);
        check("t1_seg2_x", {27'd0, rx}, 32'd14);
        check("t1_seg2_y", {27'd0, ry}, 32'd12);

`ifndef SNAKE_WALL_KILL_EN
        // T2: wrap on x; reversing left then lands on the body
        for (int i = 0; i < 16; i++) step(3'd4, 1'b0);
        check("t2_head_x_wrap", {27'd0, cabeza_x}, 32'd0);
        check("t2_head_y", {27'd0, cabeza_y}, 32'd12);
        check("t2_choque_none", {31'd0, choque}, 32'd0);
        step(3'd3, 1'b0);
        check("t2_head_x_left", {27'd0, cabeza_x}, 32'd31);
        check("t2_reverse_choque", {31'd0, choque}, 32'd1);

        // Wrap on y: 13 ups from y=12 lands on 23
        do_reset();
        for (int i = 0; i < 13; i++) step(3'd1, 1'b0);
        check("ywrap_head_y", {27'd0, cabeza_y}, 32'd23);
        check("ywrap_choque", {31'd0, choque}, 32'd0);
`endif

        // T3: growth plus ignored actions
        do_reset();
        step(3'd1, 1'b1);
        check("t3_len", {27'd0, longitud}, 32'd4);
        check("t3_head_x", {27'd0, cabeza_x}, 32'd16);
        check("t3_head_y", {27'd0, cabeza_y}, 32'd11);
        read_seg(4'd3, rx, ry, rv);
        check("t3_seg3_x", {27'd0, rx}, 32'd14);
        check("t3_seg3_y", {27'd0, ry}, 32'd12);
        check("t3_seg3_v", {31'd0, rv}, 32'd1);
        step(3'd0, 1'b0);
        step(3'd6, 1'b0);
        check("t3_noop_head_y", {27'd0, cabeza_y}, 32'd11);
        read_seg(4'd1, rx, ry, rv);
        check("t3_noop_seg1_y", {27'd0, ry}, 32'd12);
        check("t3_noop_len", {27'd0, longitud}, 32'd4);

        // T4: grow twice, then loop into own body
        do_reset();
        step(3'd4, 1'b1);
        step(3'd4, 1'b1);
        check("t4_len", {27'd0, longitud}, 32'd5);
        check("t4_head_x", {27'd0, cabeza_x}, 32'd18);
        step(3'd1, 1'b0);
        step(3'd3, 1'b0);
        check("t4_choque_pre", {31'd0, choque}, 32'd0);
        @(negedge clk);
        paso   = 1'b1;
        accion = 3'd2;
        @(posedge clk);
        #1;
        paso   = 1'b0;
        accion = 3'd0;
        n = 1;
        while (!choque && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_choque", {31'd0, choque}, 32'd1);
        check("t4_head_x", {27'd0, cabeza_x}, 32'd17);
        check("t4_head_y", {27'd0, cabeza_y}, 32'd12);
        step(3'd4, 1'b1);
        check("t4_dead_head_x", {27'd0, cabeza_x}, 32'd17);
        check("t4_dead_len", {27'd0, longitud}, 32'd5);
        check("t4_dead_choque", {31'd0, choque}, 32'd1);

        // T5: paso while busy is dropped; invalid read index
        do_reset();
        @(negedge clk);
        paso   = 1'b1;
        accion = 3'd4;
        @(posedge clk);
        #1;
        accion = 3'd4;
        @(posedge clk);
        #1;
        paso   = 1'b0;
        accion = 3'd0;
        n = 0;
        while (ocupado && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t5_head_x_once", {27'd0, cabeza_x}, 32'd17);
        check("t5_ocupado", {31'd0, ocupado}, 32'd0);
        read_seg(4'd4, rx, ry, rv);
        check("t5_idx4_valido", {31'd0, rv}, 32'd0);
        check("t5_idx4_x", {27'd0, rx}, 32'd0);

        // Length saturates at MAX_LEN
        do_reset();
        for (int i = 0; i < 14; i++) step(3'd4, 1'b1);
        check("sat_len", {27'd0, longitud}, 32'd16);
        check("sat_head_x", {27'd0, cabeza_x}, 32'd30);
        read_seg(4'd15, rx, ry, rv);
        check("sat_tail_x", {27'd0, rx}, 32'd15);

`ifdef SNAKE_WALL_KILL_EN
        // T6: right edge kills, nothing moves
        do_reset();
        for (int i = 0; i < 15; i++) step(3'd4, 1'b0);
        check("t6_head_x_edge", {27'd0, cabeza_x}, 32'd31);
        check("t6_choque_pre", {31'd0, choque}, 32'd0);
        step(3'd4, 1'b1);
        check("t6_choque", {31'd0, choque}, 32'd1);
        check("t6_head_x", {27'd0, cabeza_x}, 32'd31);
        check("t6_len", {27'd0, longitud}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
